instruction_fetch: RTL
======================

# instruction_fetch

- Byte-serial instruction fetch stage between `program_memory` and the decoder.
- Drives the 8-bit program memory address and reads its combinational 8-bit data.
- Decides whether each instruction is 1 or 2 bytes and assembles it.
- Presents it to the decoder with a valid/ready handshake; accepts branch redirects from the execute stage.

## Interface
- `RESET_PC`, default 8'd0: fetch address loaded on reset.
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: reset, synchronous, active-low.
- `mem_addr` out 8: program memory address; always equals the internal fetch pointer `pc`.
- `mem_data` in 8: program memory byte at `mem_addr`, same cycle, combinational.
- `instr_valid` out 1: assembled instruction available.
- `instr_ready` in 1: decoder accepts the instruction this cycle.
- `instr_byte0` out 8: opcode byte.
- `instr_byte1` out 8: immediate or target byte; 8'd0 for 1-byte instructions.
- `instr_len2` out 1: instruction is 2 bytes.
- `instr_pc` out 8: address of `instr_byte0`.
- `redirect_valid` in 1: branch taken; flush and refetch.
- `redirect_addr` in 8: new fetch address.
- `stall_count` out 16: decoder back-pressure cycle count (see Configuration).

## Operation
**Length rule (`is_two_byte(b)`)**
- An instruction is 2 bytes when `b[7:4]` is 4'b1010 or 4'b1011 (branches), or `b[7:2]` is 6'b100000 or 6'b100011 (MOV_IMM, CMP_IMM).
- All other opcodes are 1 byte.

**States**
- EMPTY
  - Sample `mem_data` into byte0 and capture `instr_pc` = `pc`.
  - `pc` <= `pc`+1.
  - Next state: FETCH1 if 2-byte, else HOLD.
- FETCH1
  - Sample `mem_data` into byte1.
  - `pc` <= `pc`+1.
  - Next state: HOLD.
- HOLD
  - `instr_valid`=1; outputs stable until accepted.
  - On `instr_valid && instr_ready`, the next instruction's byte0 is captured in the same cycle, exactly as in EMPTY.
  - Next state after an accept: HOLD or FETCH1.
  - With no accept, state and `pc` hold.

**Redirect**
- `redirect_valid` has top priority in every state.
- `pc` <= `redirect_addr`, state <= EMPTY, `instr_valid` <= 0; any partial or held instruction is discarded.
- Redirect in the same cycle as an accept: the accept counts as completed; the redirect still sets the next `pc`.

**Wrap and width**
- `pc` is 8 bits and wraps 255 -> 0 without a flag.
- A 2-byte instruction at 255 takes byte1 from address 0.

## Timing
**Reset (`reset`=0)**
- `pc`=`RESET_PC`, state EMPTY.
- `instr_valid`=0, `instr_byte0`=0, `instr_byte1`=0, `instr_len2`=0, `instr_pc`=0, `stall_count`=0.
- Reset mid-instruction discards it. Program memory loads its contents during reset, so the first fetch is the first cycle with `reset`=1.

**Latency**
- 1-byte instruction: `instr_valid` the cycle after EMPTY.
- 2-byte instruction: `instr_valid` two cycles after EMPTY.

**Throughput with `instr_ready`=1**
- 1-byte instructions: one per cycle.
- 2-byte instructions: one per two cycles.

**Redirect**
- Redirect at edge N: `mem_addr`=`redirect_addr` during cycle N+1.
- First redirected instruction valid at N+2 (1-byte) or N+3 (2-byte).

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_count` increments on every cycle with `instr_valid && !instr_ready`.
  - Saturates at 16'hFFFF.
  - Cleared only by reset; unaffected by redirect.
- Undefined: `stall_count` tied to 16'd0 and no counter register is built.

## Structure
**Package `fetch_pkg`**
- State enum {EMPTY, FETCH1, HOLD}.
- Opcode constants: MOV_IMM 6'b100000, CMP_IMM 6'b100011, BRA 8'hA8, BHI 8'hB0, BEQ 8'hB4, NOP 8'h70.
- `is_two_byte` function, shared with the decoder.

**Sub-module**
- Optional `instr_length_decode` (combinational, byte in -> len2 out); otherwise the package function is used inline.

## Test plan
- Memory 0:{80,00},2:{98},3:{70}, `instr_ready`=1 after reset -> MOV_IMM (pc0, byte1 00, len2=1), then 98 (pc2), then 70 (pc3) on consecutive cycles.
- `instr_ready`=0 for 5 cycles while HOLD on 98 -> outputs stable, `mem_addr` stays 3, `stall_count`=5 (macro on) / 0 (macro off).
- BEQ at 9 with target 0D; assert `redirect_valid`, addr 0D, in the cycle it is accepted -> next valid instruction has `instr_pc`=0D; bytes at 0B/0C never presented.
- Redirect while in FETCH1 -> partial instruction dropped, `instr_valid` stays 0, refetch from `redirect_addr`.
- `redirect_addr`=FF, rom[FF]=A8, rom[00]=1A -> BRA with `instr_pc`=FF, `instr_byte1`=1A; `mem_addr` wraps to 01.
- Reset asserted mid-HOLD for one cycle -> `instr_valid`=0 next cycle, `mem_addr`=`RESET_PC`, first instruction refetched from `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch stage and the decoder:
//   fetch FSM state encoding, opcode constants and the instruction length
//   rule is_two_byte().
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FETCH1 = 2'd1,
        HOLD   = 2'd2
    } fetch_state_t;

    // Opcode groups compared on the top six bits.
    localparam logic [5:0] MOV_IMM = 6'b100000;
    localparam logic [5:0] CMP_IMM = 6'b100011;

    // Full opcode bytes.
    localparam logic [7:0] BRA = 8'hA8;
    localparam logic [7:0] BHI = 8'hB0;
    localparam logic [7:0] BEQ = 8'hB4;
    localparam logic [7:0] NOP = 8'h70;

    // Branches (0xA?, 0xB?) and the immediate forms of MOV/CMP carry a
    // second byte; every other opcode is a single byte.
    function automatic logic is_two_byte(input logic [7:0] b);
        return (b[7:4] == BRA[7:4]) ||
               (b[7:4] == BHI[7:4]) ||
               (b[7:2] == MOV_IMM)  ||
               (b[7:2] == CMP_IMM);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//   Fetch -> decoder handshake bundle.
//     instr_valid  : assembled instruction available (fetch -> decoder)
//     instr_ready  : decoder accepts this cycle        (decoder -> fetch)
//     instr_byte0  : opcode byte
//     instr_byte1  : immediate/target byte, 0 for 1-byte instructions
//     instr_len2   : instruction is 2 bytes
//     instr_pc     : address of instr_byte0
//   Modports: master = fetch stage, slave = decoder.
// -----------------------------------------------------------------------------
interface instruction_fetch_if;

    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_byte0;
    logic [7:0] instr_byte1;
    logic       instr_len2;
    logic [7:0] instr_pc;

    modport master (
        output instr_valid,
        output instr_byte0,
        output instr_byte1,
        output instr_len2,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_byte0,
        input  instr_byte1,
        input  instr_len2,
        input  instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/instruction_fetch_instr_length_decode.sv
// -----------------------------------------------------------------------------
// instr_length_decode
//   Combinational opcode length classifier.
//     opcode : candidate opcode byte
//     len2   : 1 when the opcode is followed by an immediate/target byte
// -----------------------------------------------------------------------------
module instr_length_decode
    import fetch_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       len2
);

    assign len2 = is_two_byte(opcode);

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Byte-serial fetch stage between program_memory and the decoder. Reads one
//   byte per cycle, assembles 1- or 2-byte instructions and holds each one on
//   a valid/ready handshake until the decoder takes it. A branch redirect from
//   execute flushes any partial or held instruction and refetches.
//
//   Parameters:
//     RESET_PC        : fetch address loaded on reset
//   Ports:
//     clk             : clock, rising edge
//     reset           : synchronous, active-low reset
//     mem_addr        : program memory address (always the fetch pointer)
//     mem_data        : program memory byte at mem_addr, same cycle
//     redirect_valid  : branch taken, flush and refetch
//     redirect_addr   : new fetch address
//     stall_count     : cycles with instr_valid && !instr_ready
//     dec             : decoder handshake (instruction_fetch_if.master)
//
//   Build option:
//     FETCH_STALL_CNT_EN : when defined, stall_count is a saturating 16-bit
//                          counter cleared only by reset; otherwise it is 0
//                          and no counter is built.
// -----------------------------------------------------------------------------
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [7:0]                 mem_addr,
    input  logic [7:0]                 mem_data,
    input  logic                       redirect_valid,
    input  logic [7:0]                 redirect_addr,
    output logic [15:0]                stall_count,
    instruction_fetch_if.master        dec
);

    fetch_state_t state;
    logic [7:0]   pc;
    logic         valid_q;
    logic [7:0]   byte0_q;
    logic [7:0]   byte1_q;
    logic         len2_q;
    logic [7:0]   instr_pc_q;

    logic         byte_len2;
    logic         accept;
    logic         capture;

    instr_length_decode u_len_decode (
        .opcode (mem_data),
        .len2   (byte_len2)
    );

    assign accept  = valid_q && dec.instr_ready;
    // An opcode byte is taken whenever the stage is empty or the held
    // instruction leaves this cycle, giving one 1-byte instruction per cycle.
    assign capture = (state == EMPTY) || ((state == HOLD) && accept);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= EMPTY;
            pc         <= RESET_PC;
            valid_q    <= 1'b0;
            byte0_q    <= 8'd0;
            byte1_q    <= 8'd0;
            len2_q     <= 1'b0;
            instr_pc_q <= 8'd0;
        end else if (redirect_valid) begin
            // Any accept this cycle has already completed; only the fetch
            // pointer and the pipeline contents are replaced.
            state   <= EMPTY;
            pc      <= redirect_addr;
            valid_q <= 1'b0;
        end else if (capture) begin
            byte0_q    <= mem_data;
            byte1_q    <= 8'd0;
            len2_q     <= byte_len2;
            instr_pc_q <= pc;
            pc         <= pc + 8'd1;
            state      <= byte_len2 ? FETCH1 : HOLD;
            valid_q    <= !byte_len2;
        end else if (state == FETCH1) begin
            // pc wraps 255 -> 0, so a 2-byte opcode at 255 reads byte1 from 0.
            byte1_q <= mem_data;
            pc      <= pc + 8'd1;
            state   <= HOLD;
            valid_q <= 1'b1;
        end
    end

    assign mem_addr        = pc;
    assign dec.instr_valid = valid_q;
    assign dec.instr_byte0 = byte0_q;
    assign dec.instr_byte1 = byte1_q;
    assign dec.instr_len2  = len2_q;
    assign dec.instr_pc    = instr_pc_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= 16'd0;
        end else if (valid_q && !dec.instr_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule
